// File: rtl/keypad_conditioner_pkg.sv
// keypad_pkg: shared types and default constants for the keypad conditioner.
//   kp_state_t  - event FSM state (IDLE waits for a press, HOLD waits for full release)
//   KP_N        - default number of push-button inputs
//   KP_DEBOUNCE - default debounce length in clk cycles (10 ms at 12 MHz)
package keypad_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } kp_state_t;

    localparam int KP_N        = 10;
    localparam int KP_DEBOUNCE = 120000;

endpackage

// File: rtl/keypad_conditioner_if.sv
// keypad_conditioner_if: button bus between the raw push-buttons and the
// conditioned level/event outputs consumed by the calculator.
//   pb_raw    - raw asynchronous button levels, active-high
//   pb_db     - debounced button levels
//   key_valid - one-cycle strobe for a newly accepted key press
//   key_code  - index of the accepted key, held until the next strobe
//   key_held  - high from the strobe until every debounced button is released
// Modports: master drives the raw buttons and observes the results,
//           slave is the conditioner itself.
interface keypad_conditioner_if
    import keypad_pkg::*;
#(
    parameter int N      = KP_N,
    parameter int CODE_W = $clog2(N)
);

    logic [N-1:0]      pb_raw;
    logic [N-1:0]      pb_db;
    logic              key_valid;
    logic [CODE_W-1:0] key_code;
    logic              key_held;

    modport master (
        output pb_raw,
        input  pb_db,
        input  key_valid,
        input  key_code,
        input  key_held
    );

    modport slave (
        input  pb_raw,
        output pb_db,
        output key_valid,
        output key_code,
        output key_held
    );

endinterface

// File: rtl/keypad_conditioner_debounce.sv
// pb_debounce: single-bit conditioner, a 2-flop synchronizer followed by a
// stability counter. The debounced level only follows the synchronized input
// after it has differed from the current level for DEBOUNCE_CYCLES consecutive
// cycles; any return to the current level restarts the count.
//   clk  - system clock
//   nrst - asynchronous active-low reset
//   raw  - raw asynchronous button level
//   db   - debounced level (registered)
module pb_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = KP_DEBOUNCE
) (
    input  logic clk,
    input  logic nrst,
    input  logic raw,
    output logic db
);

    localparam int             CNT_W   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             sync1_r;
    logic             sync2_r;
    logic [CNT_W-1:0] cnt_r;
    logic             db_r;

    // Two-flop synchronizer bringing the raw level into the clk domain.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= raw;
            sync2_r <= sync2_r ^ (sync1_r ^ sync2_r);
        end
    end

    // Stability counter and accepted level; the counter is cleared on reaching
    // its terminal value, so it can never wrap.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_r <= {CNT_W{1'b0}};
            db_r  <= 1'b0;
        end else if (sync2_r == db_r) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (cnt_r == CNT_MAX) begin
            db_r  <= sync2_r;
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_r + CNT_ONE;
        end
    end

    assign db = db_r;

endmodule

// File: rtl/keypad_conditioner.sv
// keypad_conditioner: debounces every raw push-button and turns the debounced
// bus into single key events for the calculator.
//   clk  - system clock (hwclk domain)
//   nrst - asynchronous active-low reset
//   bus  - keypad_conditioner_if.slave: pb_raw in; pb_db, key_valid, key_code,
//          key_held out (all outputs registered)
// A press is reported once, as the lowest debounced index, and no further key
// is reported until every button has been released.
module keypad_conditioner
    import keypad_pkg::*;
#(
    parameter int N               = KP_N,
    parameter int DEBOUNCE_CYCLES = KP_DEBOUNCE,
    parameter int CODE_W          = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 nrst,
    keypad_conditioner_if.slave  bus
);

    logic [N-1:0]      db_s;
    logic              any_s;
    logic [CODE_W-1:0] idx_s;

    kp_state_t         state_r;
    kp_state_t         state_s;
    logic              key_valid_r;
    logic              key_valid_s;
    logic [CODE_W-1:0] key_code_r;
    logic [CODE_W-1:0] key_code_s;
    logic              key_held_r;
    logic              key_held_s;

    // Lowest set index of v; simultaneous presses resolve to the smallest key.
    function automatic logic [CODE_W-1:0] lowest_set(input logic [N-1:0] v);
        logic [CODE_W-1:0] idx;
        idx = {CODE_W{1'b0}};
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = CODE_W'(i);
            end
        end
        return idx;
    endfunction

    for (genvar g = 0; g < N; g++) begin : gen_bit
        pb_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk  (clk),
            .nrst (nrst),
            .raw  (bus.pb_raw[g]),
            .db   (db_s[g])
        );
    end

    assign any_s = |db_s;
    assign idx_s = lowest_set(db_s);

    // Event FSM next-state and next-output logic.
    always_comb begin
        state_s     = state_r;
        key_valid_s = 1'b0;
        key_code_s  = key_code_r;
        key_held_s  = key_held_r;
        case (state_r)
            IDLE: begin
                if (any_s) begin
                    key_code_s  = idx_s;
                    key_valid_s = 1'b1;
                    key_held_s  = 1'b1;
                    state_s     = HOLD;
                end else begin
                    key_held_s  = 1'b0;
                end
            end
            HOLD: begin
                // Leave only once every debounced button is released.
                if (!any_s) begin
                    key_held_s = 1'b0;
                    state_s    = IDLE;
                end else begin
                    key_held_s = 1'b1;
                end
            end
            default: begin
                key_held_s = 1'b0;
                state_s    = IDLE;
            end
        endcase
    end

    // Event FSM state and registered outputs.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r     <= IDLE;
            key_valid_r <= 1'b0;
            key_code_r  <= {CODE_W{1'b0}};
            key_held_r  <= 1'b0;
        end else begin
            state_r     <= state_s;
            key_valid_r <= key_valid_s;
            key_code_r  <= key_code_s;
            key_held_r  <= key_held_s;
        end
    end

    assign bus.pb_db     = db_s;
    assign bus.key_valid = key_valid_r;
    assign bus.key_code  = key_code_r;
    assign bus.key_held  = key_held_r;

endmodule
